// File: rtl/dispatch_queue.sv
// Decoded-instruction dispatch queue: circular FIFO between decode and rename/ROB allocation.
// Optional empty-queue bypass is compiled in with `define DISPATCH_BYPASS_EN.
package dispatch_queue_pkg;
  typedef struct packed {
    logic [4:0] rs1_arch;
    logic [4:0] rs2_arch;
    logic [4:0] rd_arch;
    logic       uses_rd;
  } decoded_bundle_t;
endpackage

module dispatch_queue
  import dispatch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            dec_valid,
  output logic            dec_ready,
  input  decoded_bundle_t dec_bundle,
  output logic            alloc_valid,
  input  logic            alloc_ready,
  output decoded_bundle_t alloc_bundle,
  output logic [4:0]      rs1_arch,
  output logic [4:0]      rs2_arch,
  input  logic            flush_valid,
  input  logic            recover_valid,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  decoded_bundle_t  r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic w_empty;
  logic w_q_valid;
  logic w_bypass;
  logic w_enq;
  logic w_deq;

  assign w_empty   = (r_count == '0);
  assign dec_ready = (r_count != FULL) && !flush_valid;
  assign w_q_valid = !w_empty && !flush_valid && !recover_valid;

`ifdef DISPATCH_BYPASS_EN
  // Empty queue: the decoder's bundle is offered directly to allocation.
  assign w_bypass     = w_empty && dec_valid && !flush_valid && !recover_valid;
  assign alloc_bundle = w_bypass ? dec_bundle : r_mem[r_head];
`else
  assign w_bypass     = 1'b0;
  assign alloc_bundle = r_mem[r_head];
`endif

  assign alloc_valid = w_q_valid || w_bypass;
  assign rs1_arch    = alloc_bundle.rs1_arch;
  assign rs2_arch    = alloc_bundle.rs2_arch;
  assign count       = r_count;

  // A bypassed bundle consumed in the same cycle is never written.
  assign w_deq = w_q_valid && alloc_ready;
  assign w_enq = dec_valid && dec_ready && !(w_bypass && alloc_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush_valid) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_tail <= r_tail + PTR_W'(1);
      if (w_deq) r_head <= r_head + PTR_W'(1);
      if (w_enq && !w_deq)      r_count <= r_count + CNT_W'(1);
      else if (!w_enq && w_deq) r_count <= r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) r_mem[r_tail] <= dec_bundle;
  end

endmodule

// File: tb/tb_dispatch_queue.sv
// Randomized self-checking bench for dispatch_queue against a queue-based reference model.
module tb_dispatch_queue;
  import dispatch_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            dec_valid = 1'b0;
  logic            dec_ready;
  decoded_bundle_t dec_bundle = '0;
  logic            alloc_valid;
  logic            alloc_ready = 1'b0;
  decoded_bundle_t alloc_bundle;
  logic [4:0]      rs1_arch;
  logic [4:0]      rs2_arch;
  logic            flush_valid = 1'b0;
  logic            recover_valid = 1'b0;
  logic [CNT_W-1:0] count;

  int unsigned tests_run = 0;
  int unsigned tests_failed = 0;

  decoded_bundle_t mq[$];

  dispatch_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_bundle(dec_bundle),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_bundle(alloc_bundle),
    .rs1_arch(rs1_arch), .rs2_arch(rs2_arch),
    .flush_valid(flush_valid), .recover_valid(recover_valid), .count(count)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic bit m_bypass();
`ifdef DISPATCH_BYPASS_EN
    return (mq.size() == 0) && dec_valid && !flush_valid && !recover_valid;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_dec_ready();
    return (mq.size() != DEPTH) && !flush_valid;
  endfunction

  function automatic bit m_alloc_valid();
    return ((mq.size() != 0) && !flush_valid && !recover_valid) || m_bypass();
  endfunction

  function automatic decoded_bundle_t m_head();
    if (m_bypass()) return dec_bundle;
    return mq[0];
  endfunction

  function automatic decoded_bundle_t mk(input int rd);
    decoded_bundle_t b;
    b.rs1_arch = 5'($urandom);
    b.rs2_arch = 5'($urandom);
    b.rd_arch  = 5'(rd);
    b.uses_rd  = 1'($urandom);
    return b;
  endfunction

  task automatic drive(input bit dv, input decoded_bundle_t b, input bit ar, input bit fl, input bit rc);
    dec_valid = dv; dec_bundle = b; alloc_ready = ar; flush_valid = fl; recover_valid = rc;
  endtask

  // Advance one clock and apply the same transfer to the model.
  task automatic step();
    bit byp, enq, deq, fl;
    decoded_bundle_t b;
    byp = m_bypass();
    deq = m_alloc_valid() && alloc_ready && !byp;
    enq = dec_valid && m_dec_ready() && !(byp && alloc_ready);
    fl  = flush_valid;
    b   = dec_bundle;
    @(posedge clk); #1;
    if (fl) mq.delete();
    else begin
      if (deq) void'(mq.pop_front());
      if (enq) mq.push_back(b);
    end
  endtask

  task automatic drain();
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2 * DEPTH && mq.size() != 0; i++) begin
      @(negedge clk);
      step();
    end
    @(negedge clk);
    tests_run++;
    if (count !== '0 || mq.size() != 0) begin
      tests_failed++;
      $display("FAIL drain_empty: count=%0d model=%0d required 0", count, mq.size());
    end
    step();
  endtask

  task automatic load(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, mk(i + 1), 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      step();
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    tests_run++;
    if (count !== '0 || alloc_valid !== 1'b0 || dec_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_state: count=%0d alloc_valid=%b dec_ready=%b required 0/0/1", count, alloc_valid, dec_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    mq.delete();
    @(negedge clk);
    tests_run++;
    if (count !== '0 || alloc_valid !== 1'b0 || dec_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL post_reset: count=%0d alloc_valid=%b dec_ready=%b required 0/0/1", count, alloc_valid, dec_ready);
    end
    step();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, mk(i + 1), 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      tests_run++;
      if (count !== CNT_W'(i < DEPTH ? i : DEPTH) || dec_ready !== (i < DEPTH)) begin
        tests_failed++;
        $display("FAIL fill_cycle%0d: count=%0d dec_ready=%b required %0d/%b", i, count, dec_ready, (i < DEPTH ? i : DEPTH), (i < DEPTH));
      end
      step();
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    tests_run++;
    if (count !== CNT_W'(DEPTH) || dec_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL fill_full: count=%0d dec_ready=%b required %0d/0", count, dec_ready, DEPTH);
    end
    step();
  endtask

  task automatic test_order();
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      tests_run++;
      if (alloc_valid !== 1'b1 || alloc_bundle.rd_arch !== 5'(i + 1) || alloc_bundle !== mq[0] || rs1_arch !== mq[0].rs1_arch) begin
        tests_failed++;
        $display("FAIL order_%0d: valid=%b rd=%0d rs1=%0d required 1/%0d/%0d", i, alloc_valid, alloc_bundle.rd_arch, rs1_arch, i + 1, mq[0].rs1_arch);
      end
      step();
    end
    @(negedge clk);
    tests_run++;
    if (count !== '0 || alloc_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL order_empty: count=%0d alloc_valid=%b required 0/0", count, alloc_valid);
    end
    step();
  endtask

  task automatic test_back_to_back();
    load(2);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, mk(10 + i), 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      tests_run++;
      if (count !== CNT_W'(2) || alloc_valid !== 1'b1 || alloc_bundle !== mq[0]) begin
        tests_failed++;
        $display("FAIL b2b_%0d: count=%0d valid=%b rd=%0d required 2/1/%0d", i, count, alloc_valid, alloc_bundle.rd_arch, mq[0].rd_arch);
      end
      step();
    end
    drain();
  endtask

  task automatic test_recover();
    decoded_bundle_t h;
    int exp_cnt;
    load(3);
    h = mq[0];
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, mk(20 + i), 1'b1, 1'b0, 1'b1);
      exp_cnt = (i == 0) ? 3 : 4;
      @(negedge clk);
      tests_run++;
      if (alloc_valid !== 1'b0 || count !== CNT_W'(exp_cnt) || alloc_bundle !== h) begin
        tests_failed++;
        $display("FAIL recover_%0d: valid=%b count=%0d rd=%0d required 0/%0d/%0d", i, alloc_valid, count, alloc_bundle.rd_arch, exp_cnt, h.rd_arch);
      end
      step();
    end
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    tests_run++;
    if (alloc_valid !== 1'b1 || alloc_bundle !== h || count !== CNT_W'(4)) begin
      tests_failed++;
      $display("FAIL recover_release: valid=%b rd=%0d count=%0d required 1/%0d/4", alloc_valid, alloc_bundle.rd_arch, count, h.rd_arch);
    end
    step();
    drain();
  endtask

  task automatic test_flush();
    load(3);
    drive(1'b1, mk(9), 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    tests_run++;
    if (dec_ready !== 1'b0 || alloc_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_gate: dec_ready=%b alloc_valid=%b required 0/0", dec_ready, alloc_valid);
    end
    step();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    tests_run++;
    if (count !== '0 || alloc_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_empty: count=%0d alloc_valid=%b required 0/0", count, alloc_valid);
    end
    step();
    drive(1'b1, mk(7), 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    step();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    tests_run++;
    if (count !== CNT_W'(1) || alloc_valid !== 1'b1 || alloc_bundle.rd_arch !== 5'd7) begin
      tests_failed++;
      $display("FAIL flush_refill: count=%0d valid=%b rd=%0d required 1/1/7", count, alloc_valid, alloc_bundle.rd_arch);
    end
    step();
    drain();
  endtask

`ifdef DISPATCH_BYPASS_EN
  task automatic test_bypass();
    decoded_bundle_t b;
    b = mk(3);
    b.rs1_arch = 5'd5;
    drive(1'b1, b, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    tests_run++;
    if (alloc_valid !== 1'b1 || rs1_arch !== 5'd5 || alloc_bundle !== b) begin
      tests_failed++;
      $display("FAIL bypass_same_cycle: valid=%b rs1=%0d required 1/5", alloc_valid, rs1_arch);
    end
    step();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    tests_run++;
    if (count !== '0 || alloc_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bypass_no_write: count=%0d valid=%b required 0/0", count, alloc_valid);
    end
    step();
  endtask
`endif

  task automatic test_random();
    decoded_bundle_t exp_b;
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 99) < 60), mk($urandom_range(0, 31)),
            1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 3),
            1'($urandom_range(0, 99) < 10));
      @(negedge clk);
      tests_run++;
      if (count !== CNT_W'(mq.size()) || dec_ready !== m_dec_ready() || alloc_valid !== m_alloc_valid()) begin
        tests_failed++;
        $display("FAIL rand_ctl_%0d: count=%0d dec_ready=%b valid=%b required %0d/%b/%b", i, count, dec_ready, alloc_valid, mq.size(), m_dec_ready(), m_alloc_valid());
      end
      if (m_alloc_valid()) begin
        exp_b = m_head();
        tests_run++;
        if (alloc_bundle !== exp_b || rs1_arch !== exp_b.rs1_arch || rs2_arch !== exp_b.rs2_arch) begin
          tests_failed++;
          $display("FAIL rand_data_%0d: bundle=%h rs1=%0d rs2=%0d required %h/%0d/%0d", i, alloc_bundle, rs1_arch, rs2_arch, exp_b, exp_b.rs1_arch, exp_b.rs2_arch);
        end
      end
      step();
    end
  endtask

  task automatic test_async_reset();
    load(2);
    #2;
    rst_n = 1'b0;
    #1;
    mq.delete();
    tests_run++;
    if (count !== '0 || alloc_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: count=%0d alloc_valid=%b required 0/0", count, alloc_valid);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    step();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_order();
    test_back_to_back();
    test_recover();
    test_flush();
`ifdef DISPATCH_BYPASS_EN
    test_bypass();
`endif
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dispatch_queue.md
DISPATCH_QUEUE -- requirements
Module: dispatch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving the number of decoded_bundle_t entries buffered (power of two, at least 2).
REQ-002 SHALL have parameter CNT_W, default $clog2(DEPTH+1), giving the width of the occupancy count.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 dec_valid  input  1  decoder offers dec_bundle.
REQ-006 dec_ready  output  1  queue accepts dec_bundle this cycle.
REQ-007 dec_bundle  input  decoded_bundle_t  decoded instruction; uses fields rs1_arch, rs2_arch, rd_arch, uses_rd.
REQ-008 alloc_valid  output  1  head bundle offered to rename/ROB allocation.
REQ-009 alloc_ready  input  1  rename/ROB allocation accepts the head bundle.
REQ-010 alloc_bundle  output  decoded_bundle_t  head bundle.
REQ-011 rs1_arch  output  5  alloc_bundle.rs1_arch, driving the RAT read port.
REQ-012 rs2_arch  output  5  alloc_bundle.rs2_arch, driving the RAT read port.
REQ-013 flush_valid  input  1  pipeline flush; discards all queued entries.
REQ-014 recover_valid  input  1  ROB recovery walk in progress; dispatch stalls.
REQ-015 count  output  CNT_W  current occupancy, 0..DEPTH.

Function
REQ-016 SHALL be a circular FIFO: head/tail pointers of $clog2(DEPTH) bits, wrapping from DEPTH-1 to 0, plus an occupancy counter.
REQ-017 dec_ready SHALL be (count != DEPTH) && !flush_valid, with no combinational path from alloc_ready.
REQ-018 Enqueue fires on dec_valid && dec_ready: write mem[tail], tail+1, count+1.
REQ-019 alloc_valid SHALL be (count != 0) && !flush_valid && !recover_valid.
REQ-020 Dequeue fires on alloc_valid && alloc_ready: head+1, count-1.
REQ-021 Simultaneous enqueue and dequeue SHALL leave count unchanged and advance both pointers.
REQ-022 alloc_bundle, rs1_arch and rs2_arch SHALL come from mem[head] when count != 0; their values are don't-care while alloc_valid=0.
REQ-023 Minimum latency, dec fire to alloc_valid, SHALL be 1 cycle when DISPATCH_BYPASS_EN is absent.
REQ-024 Entries SHALL dequeue in strict program order; an entry SHALL never be dropped or duplicated except on flush.
REQ-025 While recover_valid=1, the queue SHALL still accept enqueues until full, and head contents SHALL stay stable.
REQ-026 On flush_valid, the next edge SHALL set head=tail=0 and count=0; any enqueue or dequeue in that cycle is suppressed.
REQ-027 flush_valid SHALL take priority over recover_valid, dec_valid and alloc_ready.
REQ-028 count SHALL never exceed DEPTH nor underflow below 0.

Reset
REQ-029 On rst_n=0, asynchronously: head=0, tail=0, count=0, so dec_ready=1 and alloc_valid=0 on the first cycle after release.
REQ-030 Reset asserted mid-operation SHALL discard all entries immediately; memory contents need no reset.

Configuration
REQ-031 Macro DISPATCH_BYPASS_EN SHALL compile in an empty-queue bypass.
  - Defined, and count=0 && dec_valid && !flush_valid && !recover_valid:
    - alloc_valid=1; alloc_bundle, rs1_arch, rs2_arch taken from dec_bundle.
    - If alloc_ready=1, the bundle SHALL NOT be written, and count stays 0.
    - If alloc_ready=0, it is enqueued per REQ-018.
    - Latency 0.
  - Not defined: no bypass; latency per REQ-023.

Verification
REQ-032 Reset, then dec_valid=1 for 4 cycles with alloc_ready=0 and DEPTH=4 -> count=4, dec_ready=0, 5th bundle not accepted.
REQ-033 Fill 4 bundles with rd_arch 1,2,3,4, then alloc_ready=1 -> alloc_bundle.rd_arch 1,2,3,4 on consecutive cycles, count returns to 0.
REQ-034 count=2 with dec_valid=1 and alloc_ready=1 for 6 cycles -> count stays 2, pointers wrap, order preserved.
REQ-035 count=3, recover_valid=1 for 3 cycles -> alloc_valid=0 throughout, count rises to 4 then holds; after release the head dispatches.
REQ-036 count=3 and flush_valid=1 together with dec_valid=1 -> next cycle count=0, alloc_valid=0, flushed bundle absent.
REQ-037 With DISPATCH_BYPASS_EN: empty queue, dec_valid=1, rs1_arch=5, alloc_ready=1 -> same-cycle alloc_valid=1, rs1_arch=5, count stays 0.
